load_store_unit: RTL



---
 rtl/rv32i_types.sv | 49 ++++
 rtl/load_align.sv | 34 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared core types: load/store FSM states, access sizes, funct3 encodings
// and the legality check used when an op is accepted.
package rv32i_types;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2,
    LSU_FAULT  = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'b00,
    MEM_HALF  = 2'b01,
    MEM_WORD  = 2'b10,
    MEM_DWORD = 2'b11
  } mem_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // off is the byte offset inside the data word, zero-extended to 3 bits.
  function automatic logic lsu_illegal(input int unsigned xlen, input logic store,
                                       input logic [2:0] funct3, input logic [2:0] off);
    logic bad;
    bad = 1'b0;
    if (funct3 == 3'b111) bad = 1'b1;
    if (store && funct3[2]) bad = 1'b1;
    if ((xlen == 32) && (funct3[1:0] == 2'b11)) bad = 1'b1;
    if ((xlen == 32) && (funct3 == F3_LWU)) bad = 1'b1;
    case (mem_size_t'(funct3[1:0]))
      MEM_HALF:  if (off[0]) bad = 1'b1;
      MEM_WORD:  if (off[1:0] != 2'b00) bad = 1'b1;
      MEM_DWORD: if (off != 3'b000) bad = 1'b1;
      default:   ;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the addressed byte/half/word/dword out of the
// memory word and sign- or zero-extends it to XLEN.
module load_align
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [2:0]       funct3_i,
  output logic [XLEN-1:0]  data_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  // Mask-and-fill keeps the extension legal for XLEN=32, where a word
  // needs no fill bits at all.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    mask    = '1;
    sign    = 1'b0;
    case (mem_size_t'(funct3_i[1:0]))
      MEM_BYTE: begin mask = XLEN'(8'hFF);          sign = shifted[7];  end
      MEM_HALF: begin mask = XLEN'(16'hFFFF);       sign = shifted[15]; end
      MEM_WORD: begin mask = XLEN'(32'hFFFF_FFFF);  sign = shifted[31]; end
      default:  begin mask = '1;                    sign = 1'b0;        end
    endcase
    data_o = (shifted & mask) | ({XLEN{sign & ~funct3_i[2]}} & ~mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and the data memory port: byte-lane stores,
// extended loads, alignment faults and a stalling multi-cycle handshake.
module load_store_unit
  import rv32i_types::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int BE_W   = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [BE_W-1:0]   dmem_byte_enable,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_resp,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  localparam int OFF_W = $clog2(BE_W);

  // Handshake: an op transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so EX/MEM must hold the op until then.
  lsu_state_t       state_q;
  logic             store_q;
  logic [2:0]       funct3_q;
  logic [OFF_W-1:0] off_q;
  logic [4:0]       rd_q;

  logic [OFF_W-1:0] req_off;
  logic             illegal;
  logic [BE_W-1:0]  lane_be_d;
  logic [XLEN-1:0]  lane_wdata_d;
  logic [XLEN-1:0]  align_data;

  assign req_off   = req_addr[OFF_W-1:0];
  assign illegal   = lsu_illegal(XLEN, req_store, req_funct3, 3'(req_off));
  assign req_ready = (state_q == LSU_IDLE);
  assign stall     = (state_q != LSU_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    lane_be_d    = '1;
    lane_wdata_d = req_wdata << {req_off, 3'b000};
    if (req_store) begin
      case (mem_size_t'(req_funct3[1:0]))
        MEM_BYTE: lane_be_d = BE_W'(1)     << req_off;
        MEM_HALF: lane_be_d = BE_W'(3)     << req_off;
        MEM_WORD: lane_be_d = BE_W'(4'hF)  << req_off;
        default:  lane_be_d = '1;
      endcase
    end else begin
      lane_wdata_d = '0;
    end
  end

  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_align (
    .rdata_i  (dmem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (align_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= LSU_IDLE;
      store_q          <= 1'b0;
      funct3_q         <= 3'b000;
      off_q            <= '0;
      rd_q             <= 5'd0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_rd           <= 5'd0;
      rsp_fault        <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            off_q    <= req_off;
            rd_q     <= req_rd;
            if (illegal) begin
              state_q   <= LSU_FAULT;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_data  <= '0;
              rsp_rd    <= 5'd0;
            end else begin
              state_q          <= LSU_ACCESS;
              dmem_read        <= ~req_store;
              dmem_write       <= req_store;
              dmem_address     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              dmem_wdata       <= lane_wdata_d;
              dmem_byte_enable <= lane_be_d;
            end
          end
        end
        LSU_ACCESS: begin
          if (dmem_resp) begin
            state_q    <= LSU_RESP;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_fault  <= 1'b0;
            rsp_data   <= store_q ? '0 : align_data;
            rsp_rd     <= store_q ? 5'd0 : rd_q;
          end
        end
        default: begin
          state_q   <= LSU_IDLE;
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          rsp_data  <= '0;
          rsp_rd    <= 5'd0;
        end
      endcase
    end
  end

endmodule
